cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multicycle sequencer for the 16-bit CR16-style datapath.
- Drives instruction fetch, IR load, and the instruction decoder enable.
- Issues register-file write, flag-latch and data-memory strobes per instruction class.
- Sits between instruction/data memory, the IR/decoder and the regfile/ALU; one instruction is in flight at a time.

Parameters:
- MEM_LATENCY, 1: memory read latency in cycles (legal range 1..7); applies to instruction and load reads.
- CNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  high allows a new fetch; sampled only in S_FETCH.
- instr_op  input  4  IR[15:12]; valid from S_DECODE onward.
- instr_ext  input  4  IR[7:4].
- mem_addr_sel  output  1  0 = PC drives the memory address, 1 = Rsrc drives it.
- ir_load  output  1  IR captures memory read data this cycle.
- decoder_en  output  1  active-low: 0 lets the decoder evaluate; 1 holds it.
- flag_en  output  1  ALU flags latch this cycle.
- rf_we  output  1  regfile writes Rdest this cycle.
- wb_sel  output  1  0 = ALU result, 1 = memory read data.
- mem_we  output  1  data-memory write strobe.
- pc_en  output  1  PC <= PC+1 this cycle.
- illegal  output  1  one-cycle pulse on an undefined encoding.
- state  output  3  current state code.
- retired  output  CNT_WIDTH  count of completed instructions; wraps to 0.

Behaviour:
- States and codes: S_FETCH=0, S_FWAIT=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5. Codes 6 and 7 return to S_FETCH.
- All outputs are Moore outputs decoded from state, except rf_we, flag_en, wb_sel, mem_we and illegal, which also depend on the instruction class. Class is registered in S_DECODE.
- Reset: state=S_FETCH, retired=0, decoder_en=1, all other outputs 0. Reset mid-instruction aborts with no rf_we, mem_we or pc_en in that cycle or after.
- S_FETCH:
  - mem_addr_sel=0.
  - run=1: go to S_FWAIT and load wait counter = MEM_LATENCY-1.
  - run=0: stay in S_FETCH; nothing is issued.
- S_FWAIT:
  - Count down; ir_load=1 on the cycle the counter is 0, then go to S_DECODE.
  - Occupies exactly MEM_LATENCY cycles.
- S_DECODE: decoder_en=0 (also 0 in S_EXEC, S_MEM, S_WB). Class the instruction:
  - ALU_FLAG:
    - op=0000 with ext in {0101,0110,0111,1001,1010}.
    - op in {0101,0110,0111,1001,1010}.
  - CMP:
    - op=0000 with ext=1011.
    - op=1011.
  - ALU_NOFLAG:
    - op=0000 with ext in {0001,0010,0011,0100,1000,1100,1101,1110,1111}.
    - op in {1000,1100,1101,1110,1111}.
  - LOAD: op=0100, ext=0000.
  - STOR: op=0100, ext=0100.
  - NOP: op=0000, ext=0000 (WAIT).
  - ILLEGAL: everything else; illegal=1 for this one cycle.
- Transitions out of S_DECODE:
  - ALU_* and CMP go to S_EXEC.
  - LOAD and STOR go to S_MEM.
  - NOP and ILLEGAL go to S_WB.
- S_EXEC:
  - flag_en=1 for ALU_FLAG and CMP, else 0.
  - Next state S_WB.
- S_MEM:
  - mem_addr_sel=1.
  - STOR: mem_we=1 for exactly 1 cycle, then S_WB.
  - LOAD: hold for MEM_LATENCY cycles (same countdown as S_FWAIT), then S_WB.
- S_WB:
  - pc_en=1 and retired+1, then S_FETCH.
  - rf_we=1 only for ALU_FLAG, ALU_NOFLAG and LOAD.
  - wb_sel=1 only for LOAD.
  - CMP, STOR, NOP and ILLEGAL: rf_we=0. ILLEGAL still advances PC and counts as retired.
- Latency with L=MEM_LATENCY:
  - ALU/CMP: 4+L cycles.
  - LOAD: 3+2L cycles.
  - STOR: 5+L-1 cycles.
  - NOP/ILLEGAL: 3+L cycles.
- Exactly one pc_en pulse per instruction. rf_we and mem_we are never both high. flag_en is never high outside S_EXEC.
- retired at all-ones wraps to 0 on the next retire.
- instr_op/instr_ext changes after S_DECODE do not affect the registered class.

Test Plan:
- Reset held 2 cycles mid-S_MEM of a STOR → state=0, mem_we=0, pc_en=0, retired=0, decoder_en=1.
- L=1, run=1, ADD (op 0000, ext 0101) → states 0,1,2,3,5; flag_en on cycle 4; rf_we=1, wb_sel=0, pc_en=1 on cycle 5; retired=1.
- L=2, LOAD (0100/0000) → S_FWAIT 2 cycles, S_MEM 2 cycles; rf_we=1 with wb_sel=1 in S_WB; total 7 cycles.
- CMPI (op 1011) then STOR (0100/0100) → CMPI: flag_en=1, rf_we=0. STOR: mem_we=1 for exactly 1 cycle with mem_addr_sel=1, rf_we=0.
- op 0001 → illegal pulses 1 cycle in S_DECODE, no rf_we/flag_en, pc_en=1, retired increments.
- run=0 for 5 cycles in S_FETCH → state stays 0, no ir_load. Preload retired=16'hFFFF, retire WAIT → retired=0.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the CR16-style datapath.
// The sequencer owns the master modport; the datapath (or a bench) owns the slave side.
interface cpu_control_fsm_if;
  logic       run;
  logic [3:0] instr_op;
  logic [3:0] instr_ext;
  logic       mem_addr_sel;
  logic       ir_load;
  logic       decoder_en;
  logic       flag_en;
  logic       rf_we;
  logic       wb_sel;
  logic       mem_we;
  logic       pc_en;
  logic       illegal;

  modport master (
    input  run, instr_op, instr_ext,
    output mem_addr_sel, ir_load, decoder_en, flag_en, rf_we, wb_sel, mem_we, pc_en, illegal
  );

  modport slave (
    output run, instr_op, instr_ext,
    input  mem_addr_sel, ir_load, decoder_en, flag_en, rf_we, wb_sel, mem_we, pc_en, illegal
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle sequencer: fetch, decode, execute/memory, writeback; one instruction in flight.
// Instruction class is captured in S_DECODE so later IR changes cannot disturb the strobes.
module cpu_control_fsm #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_control_fsm_if.master    bus,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StFwait  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsAluFlag, ClsCmp, ClsAluNoFlag, ClsLoad, ClsStor, ClsNop, ClsIllegal
  } cls_e;

  localparam logic [2:0] WaitInit = 3'(MEM_LATENCY - 1);

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d, cls_dec;
  logic [2:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic mem_addr_sel, ir_load, decoder_en, flag_en, rf_we, wb_sel, mem_we, pc_en, illegal;

  always_comb begin
    cls_dec = ClsIllegal;
    case (bus.instr_op)
      4'b0000: begin
        case (bus.instr_ext)
          4'b0000:                                     cls_dec = ClsNop;
          4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010: cls_dec = ClsAluFlag;
          4'b1011:                                     cls_dec = ClsCmp;
          default:                                     cls_dec = ClsAluNoFlag;
        endcase
      end
      4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010: cls_dec = ClsAluFlag;
      4'b1011:                                     cls_dec = ClsCmp;
      4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111: cls_dec = ClsAluNoFlag;
      4'b0100: begin
        if (bus.instr_ext == 4'b0000)      cls_dec = ClsLoad;
        else if (bus.instr_ext == 4'b0100) cls_dec = ClsStor;
        else                               cls_dec = ClsIllegal;
      end
      default: cls_dec = ClsIllegal;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    retired_d    = retired_q;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    decoder_en   = 1'b1;
    flag_en      = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    mem_we       = 1'b0;
    pc_en        = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      StFetch: begin
        if (bus.run) begin
          state_d = StFwait;
          cnt_d   = WaitInit;
        end
      end
      StFwait: begin
        if (cnt_q == 3'd0) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDecode: begin
        decoder_en = 1'b0;
        cls_d      = cls_dec;
        cnt_d      = WaitInit;
        illegal    = (cls_dec == ClsIllegal);
        case (cls_dec)
          ClsAluFlag, ClsCmp, ClsAluNoFlag: state_d = StExec;
          ClsLoad, ClsStor:                 state_d = StMem;
          default:                          state_d = StWb;
        endcase
      end
      StExec: begin
        decoder_en = 1'b0;
        flag_en    = (cls_q == ClsAluFlag) || (cls_q == ClsCmp);
        state_d    = StWb;
      end
      StMem: begin
        decoder_en   = 1'b0;
        mem_addr_sel = 1'b1;
        if (cls_q == ClsStor) begin
          mem_we  = 1'b1;
          state_d = StWb;
        end else if (cnt_q == 3'd0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWb: begin
        decoder_en = 1'b0;
        pc_en      = 1'b1;
        rf_we      = (cls_q == ClsAluFlag) || (cls_q == ClsAluNoFlag) || (cls_q == ClsLoad);
        wb_sel     = (cls_q == ClsLoad);
        retired_d  = retired_q + CNT_WIDTH'(1);
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // An abort must not commit anything, even in the cycle reset is first seen.
    if (reset) begin
      rf_we  = 1'b0;
      mem_we = 1'b0;
      pc_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cls_q     <= ClsNop;
      cnt_q     <= 3'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.ir_load      = ir_load;
  assign bus.decoder_en   = decoder_en;
  assign bus.flag_en      = flag_en;
  assign bus.rf_we        = rf_we;
  assign bus.wb_sel       = wb_sel;
  assign bus.mem_we       = mem_we;
  assign bus.pc_en        = pc_en;
  assign bus.illegal      = illegal;
  assign state            = state_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench: dut1 runs with one-cycle memory, dut2 with two-cycle memory and a
// 3-bit retire counter so the wrap is reachable in a few instructions.
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_control_fsm_if if1 ();
  cpu_control_fsm_if if2 ();
  logic [2:0]  state1, state2;
  logic [15:0] ret1;
  logic [2:0]  ret2;

  cpu_control_fsm #(.MEM_LATENCY(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.master), .state(state1), .retired(ret1)
  );
  cpu_control_fsm #(.MEM_LATENCY(2), .CNT_WIDTH(3)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.master), .state(state2), .retired(ret2)
  );

  logic       sel = 1'b0;
  logic       run_r = 1'b0;
  logic [3:0] op_r = 4'b0, ext_r = 4'b0;
  assign if1.run = run_r & ~sel;
  assign if2.run = run_r & sel;
  assign if1.instr_op = op_r;
  assign if2.instr_op = op_r;
  assign if1.instr_ext = ext_r;
  assign if2.instr_ext = ext_r;

  logic [2:0]  o_state;
  logic [15:0] o_ret;
  logic o_mas, o_irl, o_dec, o_flag, o_rf, o_wbs, o_mw, o_pc, o_ill;
  always_comb begin
    o_state = sel ? state2 : state1;
    o_ret   = sel ? {13'b0, ret2} : ret1;
    o_mas   = sel ? if2.mem_addr_sel : if1.mem_addr_sel;
    o_irl   = sel ? if2.ir_load : if1.ir_load;
    o_dec   = sel ? if2.decoder_en : if1.decoder_en;
    o_flag  = sel ? if2.flag_en : if1.flag_en;
    o_rf    = sel ? if2.rf_we : if1.rf_we;
    o_wbs   = sel ? if2.wb_sel : if1.wb_sel;
    o_mw    = sel ? if2.mem_we : if1.mem_we;
    o_pc    = sel ? if2.pc_en : if1.pc_en;
    o_ill   = sel ? if2.illegal : if1.illegal;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-instruction observations filled by run_instr.
  int         cyc, n_flag, n_rf, n_mw, n_ill, n_irl, n_viol, wbs_at_pc;
  logic [2:0] seq [16];
  logic       flg [16];
  logic       done;
  logic [15:0] exp_r1 = 16'd0;
  logic [2:0]  exp_r2 = 3'd0;

  task automatic run_instr(input logic s, input logic [3:0] op, input logic [3:0] ext);
    logic decoded;
    sel = s; op_r = op; ext_r = ext; run_r = 1'b1;
    #1;
    cyc = 0; n_flag = 0; n_rf = 0; n_mw = 0; n_ill = 0; n_irl = 0; n_viol = 0;
    wbs_at_pc = 0; done = 1'b0; decoded = 1'b0;
    for (int i = 0; i < 16; i++) begin seq[i] = 3'd7; flg[i] = 1'b0; end
    for (int c = 0; c < 40; c++) begin
      if (c < 16) begin seq[c] = o_state; flg[c] = o_flag; end
      cyc++;
      n_flag += int'(o_flag);
      n_rf   += int'(o_rf);
      n_mw   += int'(o_mw);
      n_ill  += int'(o_ill);
      n_irl  += int'(o_irl);
      if (o_rf && o_mw) n_viol++;
      if (o_flag && o_state != 3'd3) n_viol++;
      if (o_mw && !o_mas) n_viol++;
      if (o_dec !== (o_state < 3'd2)) n_viol++;
      if (o_state == 3'd2) decoded = 1'b1;
      if (o_pc) begin
        wbs_at_pc = int'(o_wbs);
        done = 1'b1;
        break;
      end
      @(negedge clk);
      run_r = 1'b0;
      // IR contents changing after decode must not alter the committed class.
      if (decoded) begin op_r = 4'b0001; ext_r = 4'b0011; end
      #1;
    end
    chk($sformatf("pc_en reached op=%h ext=%h", op, ext), {31'b0, done}, 32'd1);
    @(negedge clk);
    #1;
    if (s) begin
      exp_r2 = exp_r2 + 3'd1;
      chk("retired dut2", {16'b0, o_ret}, {29'b0, exp_r2});
    end else begin
      exp_r1 = exp_r1 + 16'd1;
      chk("retired dut1", {16'b0, o_ret}, {16'b0, exp_r1});
    end
    chk("back in fetch", {29'b0, o_state}, 32'd0);
    chk("single pc_en", {31'b0, o_pc}, 32'd0);
  endtask

  typedef struct {
    logic       s;
    logic [3:0] op;
    logic [3:0] ext;
    int         cyc;
    int         flag;
    int         rf;
    int         wbs;
    int         mw;
    int         ill;
  } vec_t;

  vec_t vt [16];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          s     op       ext      cyc flag rf wbs mw ill
    vt[0]  = '{1'b0, 4'h0, 4'h5, 5, 1, 1, 0, 0, 0};  // ADD
    vt[1]  = '{1'b0, 4'h5, 4'h0, 5, 1, 1, 0, 0, 0};
    vt[2]  = '{1'b0, 4'h0, 4'hB, 5, 1, 0, 0, 0, 0};  // CMP
    vt[3]  = '{1'b0, 4'hB, 4'h3, 5, 1, 0, 0, 0, 0};  // CMPI
    vt[4]  = '{1'b0, 4'h0, 4'h1, 5, 0, 1, 0, 0, 0};
    vt[5]  = '{1'b0, 4'hC, 4'h7, 5, 0, 1, 0, 0, 0};
    vt[6]  = '{1'b0, 4'h4, 4'h0, 5, 0, 1, 1, 0, 0};  // LOAD
    vt[7]  = '{1'b0, 4'h4, 4'h4, 5, 0, 0, 0, 1, 0};  // STOR
    vt[8]  = '{1'b0, 4'h0, 4'h0, 4, 0, 0, 0, 0, 0};  // WAIT
    vt[9]  = '{1'b0, 4'h1, 4'h0, 4, 0, 0, 0, 0, 1};
    vt[10] = '{1'b0, 4'h4, 4'h2, 4, 0, 0, 0, 0, 1};
    vt[11] = '{1'b1, 4'h4, 4'h0, 7, 0, 1, 1, 0, 0};  // LOAD, L=2
    vt[12] = '{1'b1, 4'h0, 4'h5, 6, 1, 1, 0, 0, 0};
    vt[13] = '{1'b1, 4'h4, 4'h4, 6, 0, 0, 0, 1, 0};
    vt[14] = '{1'b1, 4'h0, 4'h0, 5, 0, 0, 0, 0, 0};
    vt[15] = '{1'b1, 4'h3, 4'hF, 5, 0, 0, 0, 0, 1};

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("reset state", {29'b0, o_state}, 32'd0);
      chk("reset retired", {16'b0, o_ret}, 32'd0);
      chk("reset decoder_en", {31'b0, o_dec}, 32'd1);
      chk("reset strobes",
          {23'b0, o_mas, o_irl, o_flag, o_rf, o_wbs, o_mw, o_pc, o_ill, 1'b0}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 16; i++) begin
      run_instr(vt[i].s, vt[i].op, vt[i].ext);
      chk($sformatf("v%0d cycles", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d flag_en", i), n_flag, vt[i].flag);
      chk($sformatf("v%0d rf_we", i), n_rf, vt[i].rf);
      chk($sformatf("v%0d wb_sel", i), wbs_at_pc, vt[i].wbs);
      chk($sformatf("v%0d mem_we", i), n_mw, vt[i].mw);
      chk($sformatf("v%0d illegal", i), n_ill, vt[i].ill);
      chk($sformatf("v%0d ir_load", i), n_irl, 1);
      chk($sformatf("v%0d invariants", i), n_viol, 0);
    end

    // ADD at L=1: state trace and flag timing.
    run_instr(1'b0, 4'h0, 4'h5);
    chk("add seq", {seq[0], seq[1], seq[2], seq[3], seq[4]},
        {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
    chk("add flag cycle4", {28'b0, flg[0], flg[1], flg[2], flg[3]}, 32'b0001);

    // LOAD at L=2: two fetch-wait and two memory cycles.
    run_instr(1'b1, 4'h4, 4'h0);
    chk("load L2 seq", {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6]},
        {3'd0, 3'd1, 3'd1, 3'd2, 3'd4, 3'd4, 3'd5});

    // run=0 holds in fetch.
    sel = 1'b0; run_r = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("idle state", {29'b0, o_state}, 32'd0);
      chk("idle ir_load", {31'b0, o_irl}, 32'd0);
    end

    // Retire counter wrap on the narrow instance.
    for (int k = 0; k < 8 && exp_r2 != 3'd7; k++) run_instr(1'b1, 4'h0, 4'h0);
    chk("retired at max", {16'b0, o_ret}, 32'd7);
    run_instr(1'b1, 4'h0, 4'h0);
    chk("retired wrap", {16'b0, o_ret}, 32'd0);

    // Reset asserted during the STOR memory cycle.
    sel = 1'b0; op_r = 4'h4; ext_r = 4'h4; run_r = 1'b1;
    #1;
    for (int c = 0; c < 10 && o_state != 3'd4; c++) begin
      @(negedge clk);
      run_r = 1'b0;
      #1;
    end
    chk("reached S_MEM", {29'b0, o_state}, 32'd4);
    chk("stor mem_we pre", {31'b0, o_mw}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort mem_we", {31'b0, o_mw}, 32'd0);
    chk("abort pc_en", {31'b0, o_pc}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst state", {29'b0, o_state}, 32'd0);
      chk("rst mem_we", {31'b0, o_mw}, 32'd0);
      chk("rst pc_en", {31'b0, o_pc}, 32'd0);
      chk("rst decoder_en", {31'b0, o_dec}, 32'd1);
      chk("rst retired", {16'b0, o_ret}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post-rst state", {29'b0, o_state}, 32'd0);
    chk("post-rst retired", {16'b0, o_ret}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
